// File: rtl/user_fifo_axis_drain.sv
// ============================================================================
// Module   : user_fifo_axis_drain
// Brief    : Drains the 75x512 user FIFO into an AXI4-Stream master with
//            maximum-frame-length truncation and a wrapping frame counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module user_fifo_axis_drain #(
  parameter int DATA_W    = 64,
  parameter int KEEP_W    = 8,
  parameter int FIFO_W    = 75,
  parameter int MAX_BEATS = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FIFO_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic [1:0]        m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              trunc_err,
  output logic              busy
);

  localparam int c_LAST_BIT = DATA_W + KEEP_W;
  localparam int c_USER_LSB = c_LAST_BIT + 1;
  localparam int c_ENT_W    = DATA_W + KEEP_W + 3;
  localparam int c_BEAT_W   = $clog2(MAX_BEATS + 1);

  localparam logic [c_BEAT_W-1:0] c_MAX_BEATS = c_BEAT_W'(MAX_BEATS);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_FRAME   = 2'd1;
  localparam logic [1:0] c_DISCARD = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic [c_BEAT_W-1:0] r_beat_cnt;
  logic [c_BEAT_W-1:0] w_beat_next;
  logic                r_inflight;
  logic [1:0]          r_occ;
  logic [c_ENT_W-1:0]  r_buf0;
  logic [c_ENT_W-1:0]  r_buf1;
  logic [c_ENT_W-1:0]  w_entry;
  logic [2:0]          w_level;
  logic                w_pop;
  logic                w_push;
  logic                w_trunc;
  logic                w_word_last;
  logic                r_trunc_err;
  logic [CNT_W-1:0]    r_frame_cnt;

  assign w_word_last = fifo_dout[c_LAST_BIT];
  assign w_beat_next = (r_state == c_IDLE) ? c_BEAT_W'(1) : r_beat_cnt + c_BEAT_W'(1);

  // ---------------- framing FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_push) begin
        r_beat_cnt <= w_beat_next;
      end
    end
  end

  // ---------------- framing FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    if (r_inflight) begin
      case (r_state)
        c_IDLE, c_FRAME: begin
          if (w_word_last)  w_state_next = c_IDLE;
          else if (w_trunc) w_state_next = c_DISCARD;
          else              w_state_next = c_FRAME;
        end
        c_DISCARD: begin
          if (w_word_last) w_state_next = c_IDLE;
        end
        default: w_state_next = c_IDLE;
      endcase
    end
  end

  // ---------------- framing FSM: outputs ----------------
  always_comb begin
    w_push  = r_inflight && (r_state != c_DISCARD);
    // A non-last word landing on the final allowed beat closes the frame itself.
    w_trunc = w_push && !w_word_last && (w_beat_next == c_MAX_BEATS);
    w_entry = {fifo_dout[c_USER_LSB +: 2], (w_word_last | w_trunc),
               fifo_dout[KEEP_W+DATA_W-1:0]};
  end

  // ---------------- read pipeline ----------------
  assign w_pop   = m_axis_tvalid && m_axis_tready;
  assign w_level = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
  // Only issue a read if the buffer can still hold it when it returns.
  assign fifo_rd_en = rst_n && !fifo_empty && (w_level < 3'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ  <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_buf0 <= w_entry;
          else               r_buf1 <= w_entry;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= w_entry;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= w_entry;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- counters and status ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_trunc_err <= 1'b0;
    end else begin
      r_trunc_err <= w_trunc;
      if (w_pop && r_buf0[c_LAST_BIT]) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

  assign m_axis_tvalid = (r_occ != 2'd0);
  assign m_axis_tdata  = r_buf0[DATA_W-1:0];
  assign m_axis_tkeep  = r_buf0[DATA_W +: KEEP_W];
  assign m_axis_tlast  = r_buf0[c_LAST_BIT];
  assign m_axis_tuser  = r_buf0[c_USER_LSB +: 2];
  assign frame_cnt     = r_frame_cnt;
  assign trunc_err     = r_trunc_err;
  assign busy          = (r_state != c_IDLE) || (r_occ != 2'd0) || r_inflight;

endmodule

`default_nettype wire

// File: tb/tb_user_fifo_axis_drain.sv
// ============================================================================
// Module   : tb_user_fifo_axis_drain
// Brief    : Directed self-checking bench for user_fifo_axis_drain with a
//            standard-mode FIFO model and an AXI-Stream beat collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_user_fifo_axis_drain;

  localparam int DATA_W = 64, KEEP_W = 8, FIFO_W = 75, MAX_BEATS = 32, CNT_W = 16;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [FIFO_W-1:0] fifo_dout = '0;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic              m_axis_tlast;
  logic [1:0]        m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic [CNT_W-1:0]  frame_cnt;
  logic              trunc_err;
  logic              busy;

  always #5 clk = ~clk;

  user_fifo_axis_drain #(
    .DATA_W(DATA_W), .KEEP_W(KEEP_W), .FIFO_W(FIFO_W),
    .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .frame_cnt(frame_cnt), .trunc_err(trunc_err), .busy(busy)
  );

  // Standard-mode FIFO model: data appears one cycle after rd_en, cleared by ~rst_n.
  logic [FIFO_W-1:0] mem [0:DEPTH-1];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= wr_ptr;
      fifo_dout <= '0;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr[9:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Beat collector and protocol observers, sampled mid-cycle.
  logic [FIFO_W-1:0] beats[$];
  int rd_cnt, rd_first, rd_last, beat_first, beat_last;
  int tlast_cnt, trunc_cnt, rd_empty_viol, stall_viol, max_out;
  logic              prev_stall;
  logic [FIFO_W-1:0] prev_payload;

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_rd_en) begin
        if (fifo_empty) rd_empty_viol++;
        if (rd_cnt == 0) rd_first = cyc;
        rd_last = cyc;
        rd_cnt++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats.push_back({m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata});
        if (beats.size() == 1) beat_first = cyc;
        beat_last = cyc;
        if (m_axis_tlast) tlast_cnt++;
      end
      if (trunc_err) trunc_cnt++;
      if (rd_cnt - int'(beats.size()) > max_out) max_out = rd_cnt - int'(beats.size());
      if (prev_stall && (!m_axis_tvalid ||
          {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} != prev_payload))
        stall_viol++;
      prev_stall   = m_axis_tvalid && !m_axis_tready;
      prev_payload = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [FIFO_W-1:0] mkw(input int tag, input int idx,
                                            input logic last, input logic [7:0] keep);
    mkw = {2'(idx), last, keep, 16'hDA7A, 16'(tag), 32'(idx)};
  endfunction

  task automatic clear_mon;
    beats.delete();
    rd_cnt = 0; rd_first = 0; rd_last = 0; beat_first = 0; beat_last = 0;
    tlast_cnt = 0; trunc_cnt = 0; rd_empty_viol = 0; stall_viol = 0; max_out = 0;
    prev_stall = 1'b0; prev_payload = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic push_word(input logic [FIFO_W-1:0] w);
    int g;
    g = 0;
    while (wr_ptr - rd_ptr >= DEPTH - 8) begin
      @(posedge clk); #1;
      g++;
      if (g > 20000) begin
        $display("FAIL fifo_drain_stall: level=%0d required below %0d", wr_ptr - rd_ptr, DEPTH - 8);
        $fatal(1, "FIFO never drained");
      end
    end
    mem[wr_ptr[9:0]] = w;
    wr_ptr++;
  endtask

  task automatic wait_done(input int n, input int bound, output bit to);
    to = 1'b1;
    for (int k = 0; k < bound; k++) begin
      @(posedge clk); #1;
      if (beats.size() >= n && !busy && fifo_empty) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    do_reset();
    n_assert++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b required 0", m_axis_tvalid); end
    n_assert++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b required 0", fifo_rd_en); end
    n_assert++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_assert++; if (trunc_err !== 1'b0) begin n_fail++; $display("FAIL reset_trunc_err: got %b required 0", trunc_err); end
    n_assert++; if ({m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== 75'd0) begin
      n_fail++; $display("FAIL reset_payload: got %h required 0", {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}); end
  endtask

  task automatic test_stream;
    bit to;
    logic [FIFO_W-1:0] exp;
    do_reset();
    for (int i = 1; i <= 50; i++) push_word(mkw(1, i, (i % 10 == 0), 8'hFF));
    wait_done(50, 500, to);
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL stream_timeout: got %0d required 0", to); end
    n_assert++; if (beats.size() != 50) begin n_fail++; $display("FAIL stream_beats: got %0d required 50", beats.size()); end
    for (int i = 0; i < 50 && i < beats.size(); i++) begin
      exp = mkw(1, i + 1, ((i + 1) % 10 == 0), 8'hFF);
      n_assert++; if (beats[i] !== exp) begin n_fail++; $display("FAIL stream_beat%0d: got %h required %h", i, beats[i], exp); end
    end
    n_assert++; if (tlast_cnt != 5) begin n_fail++; $display("FAIL stream_tlast: got %0d required 5", tlast_cnt); end
    n_assert++; if (frame_cnt !== 16'd5) begin n_fail++; $display("FAIL stream_frame_cnt: got %0d required 5", frame_cnt); end
    n_assert++; if (trunc_cnt != 0) begin n_fail++; $display("FAIL stream_trunc: got %0d required 0", trunc_cnt); end
    n_assert++; if (rd_cnt != 50 || rd_last - rd_first != 49) begin
      n_fail++; $display("FAIL stream_rd_contig: got %0d reads over %0d cycles required 50 over 50", rd_cnt, rd_last - rd_first + 1); end
    n_assert++; if (beat_last - beat_first != 49) begin
      n_fail++; $display("FAIL stream_b2b: got span %0d required 49", beat_last - beat_first); end
    n_assert++; if (rd_empty_viol != 0) begin n_fail++; $display("FAIL stream_rd_empty: got %0d required 0", rd_empty_viol); end
  endtask

  task automatic test_backpressure;
    bit to;
    logic [FIFO_W-1:0] exp;
    do_reset();
    for (int i = 1; i <= 50; i++) push_word(mkw(2, i, (i % 10 == 0), 8'hFF));
    to = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      m_axis_tready = ~m_axis_tready;
      if (beats.size() >= 50 && !busy && fifo_empty) begin to = 1'b0; break; end
    end
    m_axis_tready = 1'b1;
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %0d required 0", to); end
    n_assert++; if (beats.size() != 50) begin n_fail++; $display("FAIL bp_beats: got %0d required 50", beats.size()); end
    for (int i = 0; i < 50 && i < beats.size(); i++) begin
      exp = mkw(2, i + 1, ((i + 1) % 10 == 0), 8'hFF);
      n_assert++; if (beats[i] !== exp) begin n_fail++; $display("FAIL bp_beat%0d: got %h required %h", i, beats[i], exp); end
    end
    n_assert++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d required 0", stall_viol); end
    n_assert++; if (rd_empty_viol != 0) begin n_fail++; $display("FAIL bp_rd_empty: got %0d required 0", rd_empty_viol); end
    n_assert++; if (max_out > 2) begin n_fail++; $display("FAIL bp_outstanding: got %0d required at most 2", max_out); end
    n_assert++; if (frame_cnt !== 16'd5) begin n_fail++; $display("FAIL bp_frame_cnt: got %0d required 5", frame_cnt); end
  endtask

  task automatic test_truncate;
    bit to;
    logic [FIFO_W-1:0] exp;
    do_reset();
    for (int i = 1; i <= 40; i++) push_word(mkw(3, i, (i == 40), 8'hFF));
    wait_done(32, 500, to);
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL trunc_timeout: got %0d required 0", to); end
    n_assert++; if (beats.size() != 32) begin n_fail++; $display("FAIL trunc_beats: got %0d required 32", beats.size()); end
    for (int i = 0; i < 32 && i < beats.size(); i++) begin
      exp = mkw(3, i + 1, (i == 31), 8'hFF);
      n_assert++; if (beats[i] !== exp) begin n_fail++; $display("FAIL trunc_beat%0d: got %h required %h", i, beats[i], exp); end
    end
    n_assert++; if (trunc_cnt != 1) begin n_fail++; $display("FAIL trunc_pulse: got %0d required 1", trunc_cnt); end
    n_assert++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL trunc_frame_cnt: got %0d required 1", frame_cnt); end
    for (int i = 1; i <= 5; i++) push_word(mkw(4, i, (i == 5), 8'hFF));
    wait_done(37, 500, to);
    n_assert++; if (to !== 1'b0 || beats.size() != 37) begin
      n_fail++; $display("FAIL trunc_next_beats: got %0d required 37", beats.size()); end
    for (int i = 32; i < 37 && i < beats.size(); i++) begin
      exp = mkw(4, i - 31, (i == 36), 8'hFF);
      n_assert++; if (beats[i] !== exp) begin n_fail++; $display("FAIL trunc_next_beat%0d: got %h required %h", i, beats[i], exp); end
    end
    n_assert++; if (frame_cnt !== 16'd2 || trunc_cnt != 1) begin
      n_fail++; $display("FAIL trunc_next_count: got frames %0d pulses %0d required 2 and 1", frame_cnt, trunc_cnt); end
  endtask

  task automatic test_max_legal;
    bit to;
    logic [FIFO_W-1:0] exp;
    do_reset();
    for (int i = 1; i <= 32; i++) push_word(mkw(5, i, (i == 32), 8'hFF));
    wait_done(32, 500, to);
    n_assert++; if (to !== 1'b0 || beats.size() != 32) begin
      n_fail++; $display("FAIL max_beats: got %0d required 32", beats.size()); end
    n_assert++; if (beats.size() == 32 && beats[31] !== mkw(5, 32, 1'b1, 8'hFF)) begin
      n_fail++; $display("FAIL max_last_beat: got %h required %h", beats[31], mkw(5, 32, 1'b1, 8'hFF)); end
    n_assert++; if (tlast_cnt != 1) begin n_fail++; $display("FAIL max_tlast: got %0d required 1", tlast_cnt); end
    n_assert++; if (trunc_cnt != 0) begin n_fail++; $display("FAIL max_trunc: got %0d required 0", trunc_cnt); end
    n_assert++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL max_frame_cnt: got %0d required 1", frame_cnt); end
    for (int i = 1; i <= 3; i++) push_word(mkw(6, i, 1'b1, 8'h0F));
    wait_done(35, 200, to);
    n_assert++; if (to !== 1'b0 || beats.size() != 35) begin
      n_fail++; $display("FAIL single_beats: got %0d required 35", beats.size()); end
    for (int i = 32; i < 35 && i < beats.size(); i++) begin
      exp = mkw(6, i - 31, 1'b1, 8'h0F);
      n_assert++; if (beats[i] !== exp) begin n_fail++; $display("FAIL single_beat%0d: got %h required %h", i, beats[i], exp); end
    end
    n_assert++; if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL single_frame_cnt: got %0d required 4", frame_cnt); end
  endtask

  task automatic test_mid_reset;
    bit to;
    logic [FIFO_W-1:0] exp;
    do_reset();
    push_word(mkw(7, 1, 1'b1, 8'h0F));
    wait_done(1, 100, to);
    n_assert++; if (to !== 1'b0 || frame_cnt !== 16'd1) begin
      n_fail++; $display("FAIL midrst_pre_frame: got %0d required 1", frame_cnt); end
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 10; i++) push_word(mkw(7, i, 1'b0, 8'hFF));
    repeat (8) @(posedge clk);
    #1;
    n_assert++; if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_held: got tvalid %b busy %b required 1 1", m_axis_tvalid, busy); end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_assert++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_tvalid: got %b required 0", m_axis_tvalid); end
    n_assert++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_frame_cnt: got %0d required 0", frame_cnt); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b required 0", busy); end
    clear_mon();
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 3; i++) push_word(mkw(8, i, (i == 3), 8'hFF));
    wait_done(3, 100, to);
    n_assert++; if (to !== 1'b0 || beats.size() != 3) begin
      n_fail++; $display("FAIL midrst_after_beats: got %0d required 3", beats.size()); end
    for (int i = 0; i < 3 && i < beats.size(); i++) begin
      exp = mkw(8, i + 1, (i == 2), 8'hFF);
      n_assert++; if (beats[i] !== exp) begin n_fail++; $display("FAIL midrst_beat%0d: got %h required %h", i, beats[i], exp); end
    end
    n_assert++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL midrst_after_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_cnt_wrap;
    bit to;
    do_reset();
    for (int i = 0; i < 65535; i++) push_word(mkw(9, i, 1'b1, 8'hFF));
    wait_done(65535, 5000, to);
    n_assert++; if (to !== 1'b0 || frame_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_preload: got %h required ffff", frame_cnt); end
    push_word(mkw(10, 1, 1'b1, 8'hFF));
    wait_done(65536, 200, to);
    n_assert++; if (to !== 1'b0 || frame_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_rollover: got %h required 0000", frame_cnt); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_stream();
    test_backpressure();
    test_truncate();
    test_max_legal();
    test_mid_reset();
    test_cnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
